// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered BCD display data, leading-zero
// suppression, per-slot anode dead time, and registered active-low outputs.
module seg_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [4*N_DIGITS-1:0] bcd_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic                  blank_i,
  input  logic                  lz_en_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = 4 * N_DIGITS;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       act_bcd, pend_bcd;
  logic [N_DIGITS-1:0] act_dp, pend_dp;
  logic                pend_flag;

  logic                tick, last_digit, frame_edge, in_dead, suppress;
  logic [3:0]          digit;
  logic                dp_bit, upper_zero;
  logic [N_DIGITS-1:0] an_next;

  assign tick       = (cnt == CW'(SCAN_DIV - 1));
  assign last_digit = (idx == IW'(N_DIGITS - 1));
  assign frame_edge = tick && last_digit;

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CW'(DEAD));
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Select the current digit and find whether it and every more-significant digit are zero.
  always_comb begin
    digit      = 4'd0;
    dp_bit     = 1'b0;
    upper_zero = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        digit  = act_bcd[4*k +: 4];
        dp_bit = act_dp[k];
      end
      if (IW'(k) >= idx && act_bcd[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
  end

  assign suppress = lz_en_i && (idx != '0) && upper_zero;
  assign an_next  = (blank_i || in_dead) ? '1 : ~(N_DIGITS'(1) << idx);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= last_digit ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Active only changes on a frame edge; a coincident load goes to pending and keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_bcd   <= '0;
      act_dp    <= '0;
      pend_bcd  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (frame_edge && pend_flag) begin
        act_bcd   <= pend_bcd;
        act_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end
      if (load_i) begin
        pend_bcd  <= bcd_i;
        pend_dp   <= dp_i;
        pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seg_o   <= 7'b1111111;
      dp_o    <= 1'b1;
      an_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= (blank_i || suppress) ? 7'b1111111 : decode(digit);
      dp_o    <= blank_i ? 1'b1 : ~dp_bit;
      an_o    <= an_next;
      frame_o <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (N_DIGITS=4, SCAN_DIV=4, DEAD=1) against a
// time-based reference model of the scan schedule and frame-buffered display data.
module tb_seg_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int DT = 1;
  localparam logic [12:0] RESET_OUT = {7'b1111111, 1'b1, 4'b1111, 1'b0};

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [15:0]   bcd_i = '0;
  logic [3:0]    dp_i = '0;
  logic          load_i = 1'b0, blank_i = 1'b0, lz_en_i = 1'b0;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [3:0]    an_o;
  logic          frame_o;

  int errors = 0;
  int checks = 0;

  seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .DEAD(DT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bcd_i(bcd_i), .dp_i(dp_i), .load_i(load_i),
    .blank_i(blank_i), .lz_en_i(lz_en_i), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o),
    .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: time since reset release plus the two display buffers.
  logic [6:0]  seg_tab [0:15];
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_flag;
  logic [12:0] exp_q[$];

  task automatic model_reset();
    m_t = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_flag = 1'b0;
    exp_q.delete();
  endtask

  // Drives one cycle of inputs, advances the model across the edge, pushes expected outputs.
  task automatic step(input logic ld, input logic [15:0] b, input logic [3:0] p,
                      input logic bl, input logic lz);
    int slot_pos, dig;
    logic frame, sup;
    logic [6:0] e_seg;
    logic e_dp;
    logic [3:0] e_an;
    load_i = ld; bcd_i = b; dp_i = p; blank_i = bl; lz_en_i = lz;
    @(posedge clk_i);
    slot_pos = m_t % SD;
    dig      = (m_t / SD) % N;
    frame    = ((m_t % (SD * N)) == SD * N - 1);
    sup      = lz && dig > 0 && ((m_act >> (4 * dig)) == 16'd0);
    e_an     = (bl || slot_pos < DT) ? 4'b1111 : ~(4'b0001 << dig);
    e_seg    = (bl || sup) ? 7'b1111111 : seg_tab[(m_act >> (4 * dig)) & 16'hF];
    e_dp     = bl ? 1'b1 : ~m_act_dp[dig];
    exp_q.push_back({e_seg, e_dp, e_an, frame});
    if (frame && m_flag) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_flag = 1'b0;
    end
    if (ld) begin
      m_pend = b; m_pend_dp = p; m_flag = 1'b1;
    end
    m_t++;
    #1;
    load_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    do_reset();
    obs = {seg_o, dp_o, an_o, frame_o};
    checks++;
    if (obs !== RESET_OUT) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs, RESET_OUT);
    end
  endtask

  task automatic test_scan_idle();
    logic [12:0] e, obs;
    int frames;
    frames = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      frames += int'(frame_o);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL scan_idle cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    checks++;
    if (frames != 3) begin
      errors++; $display("FAIL frame_rate got=%0d exp=3", frames);
    end
  endtask

  task automatic test_load_mid_frame();
    logic [12:0] e, obs;
    for (int i = 0; i < 48; i++) begin
      step(i == 5, 16'h1234, 4'b0100, 1'b0, 1'b0);
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL load_mid_frame cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_lz();
    logic [12:0] e, obs;
    for (int i = 0; i < 64; i++) begin
      step(i == 0, 16'h0070, 4'b0000, 1'b0, i < 36);
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL lz_supp cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [12:0] e, obs;
    for (int i = 0; i < 40; i++) begin
      step(i == 0, 16'h00A5, 4'b0000, 1'b0, 1'b0);
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL invalid_bcd cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_load_on_frame();
    logic [12:0] e, obs;
    int i;
    step(1'b1, 16'h5678, 4'b0001, 1'b0, 1'b0);
    e = exp_q.pop_front();
    while ((m_t % (SD * N)) != SD * N - 1) begin
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    step(1'b1, 16'h9012, 4'b1000, 1'b0, 1'b0);
    e = exp_q.pop_front();
    for (i = 0; i < 40; i++) begin
      step(1'b0, 16'h0, 4'h0, i >= 34, 1'b0);
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL load_on_frame cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] e, obs;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, 16'($urandom()), 4'($urandom()),
           $urandom_range(0, 7) == 0, 1'($urandom()));
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [12:0] e, obs;
    for (int i = 0; i < 7; i++) begin
      step(i == 2, 16'h4321, 4'b1111, 1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    obs = {seg_o, dp_o, an_o, frame_o};
    checks++;
    if (obs !== RESET_OUT) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs, RESET_OUT);
    end
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #2;
    obs = {seg_o, dp_o, an_o, frame_o};
    checks++;
    if (obs !== RESET_OUT) begin
      errors++; $display("FAIL release_hold got=%h exp=%h", obs, RESET_OUT);
    end
    for (int i = 0; i < 36; i++) begin
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      e = exp_q.pop_front(); obs = {seg_o, dp_o, an_o, frame_o};
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL reset_restart cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1111111;
    model_reset();
    test_reset();
    test_scan_idle();
    test_load_mid_frame();
    test_lz();
    test_invalid_bcd();
    test_load_on_frame();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
